rf_operand_fetch: RTL and testbench
===================================

Name: rf_operand_fetch

Overview:
- Operand-fetch stage directly upstream of the 32x32 register file; it is the file's only driver.
- Accepts decoded register indices over a valid/ready handshake and issues the read.
- Captures the registered read data and presents both operands, plus the destination index, downstream over a valid/ready handshake.
- Arbitrates the write-back port against reads, because the register file performs either a write or a read on a given edge, never both. Write-back has priority.

Parameters:
- ADDR_W, 5, register index width
- DATA_W, 32, register data width
- STALL_LIMIT, 4, consecutive write-blocked read cycles before the starvation guard acts (used only with the optional feature)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  fetch request valid
- req_ready  out  1  stage can accept a request
- req_rs1  in  ADDR_W  source index A
- req_rs2  in  ADDR_W  source index B
- req_rd  in  ADDR_W  destination index, passed through
- wb_valid  in  1  write-back request
- wb_ready  out  1  write-back accepted this cycle
- wb_rd  in  ADDR_W  write-back index
- wb_data  in  DATA_W  write-back data
- rf_wr  out  1  register file write enable
- rf_rw  out  ADDR_W  register file write index
- rf_din  out  DATA_W  register file write data
- rf_r1  out  ADDR_W  register file read index A
- rf_r2  out  ADDR_W  register file read index B
- rf_out1  in  DATA_W  register file read data A (registered, valid the edge after the read)
- rf_out2  in  DATA_W  register file read data B
- op_valid  out  1  operands valid
- op_ready  in  1  downstream accepts operands
- op_a  out  DATA_W  operand A
- op_b  out  DATA_W  operand B
- op_rd  out  ADDR_W  destination index

Behaviour:
- Reset is asynchronous and active-low.
  - State goes to IDLE; op_valid=0; op_a, op_b, op_rd and the latched indices go to 0.
  - While rst_n=0: req_ready=0, wb_ready=0, rf_wr=0.
- Write-back path (combinational):
  - wb_ready=1 whenever out of reset.
  - rf_wr = wb_valid & (wb_rd != 0).
  - rf_rw = wb_rd; rf_din = wb_data.
  - A write-back to index 0 is accepted and dropped, never written. The register file cannot keep register 0 at zero if written.
- Read indices: rf_r1 and rf_r2 are always driven from the latched rs1/rs2 registers.
- State machine:
  - IDLE: req_ready=1. On req_valid, latch rs1/rs2/rd and go to ISSUE.
  - ISSUE: the read is performed at the edge where rf_wr=0, then go to CAPT. If rf_wr=1, the read is lost; stay in ISSUE and retry next cycle.
  - CAPT: op_a <= (rs1==0 ? 0 : rf_out1); op_b likewise; op_rd <= rd; op_valid <= 1; go to VALID.
  - VALID: hold op_* stable while op_ready=0.
    - On op_ready=1: if req_valid, latch the new request and go to ISSUE (req_ready = op_ready in VALID); otherwise clear op_valid and go to IDLE.
- Latency: request accepted at edge N gives op_valid=1 after edge N+2 with no write-back collision. Each colliding write-back cycle adds one cycle.
- Throughput: one result per 3 cycles.
- Hazard ordering: operands reflect every write-back whose rf_wr edge precedes the read edge. A write-back on the read-attempt cycle forces a retry, so it is always visible; no bypass is needed. Later write-backs do not alter held operands.
- req_* and wb_* are independent; simultaneous arrival is legal.

Optional Feature:
- Macro: RF_OPF_STARVE_GUARD_EN.
- Defined:
  - A counter of consecutive ISSUE cycles blocked by rf_wr saturates at STALL_LIMIT.
  - When it equals STALL_LIMIT, wb_ready=0 and rf_wr=0 for one cycle, so the read is performed. The counter clears on a successful read.
  - Write-back sources must honour wb_ready.
- Undefined: no counter; wb_ready follows reset only. Continuous write-back can starve reads indefinitely.

Decomposition:
- Shared package rf_pkg:
  - ADDR_W and DATA_W constants, a REG_ZERO index constant, and the state enum (IDLE, ISSUE, CAPT, VALID).
- No sub-module. The write-back arbitration is a few combinational lines inside the block.

Test Plan:
- Write-back rd=3 data 0xDEADBEEF, then request rs1=3 rs2=0 -> op_a=0xDEADBEEF, op_b=0, op_valid after 2 edges.
- Request rs1=5 with wb_valid to rd=7 held 2 cycles during ISSUE -> rf_wr=1 both cycles, op_valid delayed 2 cycles, op_a = previous R5 value.
- Write-back rd=0 data 0xFFFFFFFF -> rf_wr=0, wb_ready=1; subsequent read of rs1=0 gives op_a=0.
- op_ready=0 for 5 cycles, then a write-back to the held rs1 -> op_a unchanged; accepting with req_valid=1 returns to ISSUE the same edge.
- Assert rst_n=0 asynchronously in CAPT -> op_valid=0, req_ready=0, state IDLE immediately.
- Guard enabled, STALL_LIMIT=4, wb_valid continuous -> after 4 blocked cycles wb_ready=0 for 1 cycle, read completes, op_valid follows 1 edge later.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and state encoding for the register-file operand-fetch stage.
package rf_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    VALID = 2'd3
  } state_e;

endpackage

// File: rtl/rf_operand_fetch.sv
// Operand fetch in front of a single-port-per-edge 32x32 register file; write-back wins arbitration.
// Optional read-starvation guard enabled by defining RF_OPF_STARVE_GUARD_EN.
module rf_operand_fetch #(
  parameter int ADDR_W      = rf_pkg::ADDR_W,
  parameter int DATA_W      = rf_pkg::DATA_W,
  parameter int STALL_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rs1,
  input  logic [ADDR_W-1:0] req_rs2,
  input  logic [ADDR_W-1:0] req_rd,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              rf_wr,
  output logic [ADDR_W-1:0] rf_rw,
  output logic [DATA_W-1:0] rf_din,
  output logic [ADDR_W-1:0] rf_r1,
  output logic [ADDR_W-1:0] rf_r2,
  input  logic [DATA_W-1:0] rf_out1,
  input  logic [DATA_W-1:0] rf_out2,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [ADDR_W-1:0] op_rd
);
  import rf_pkg::*;

  localparam logic [ADDR_W-1:0] ZERO_IDX  = ADDR_W'(REG_ZERO);
  localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

  state_e            state_r, state_s;
  logic [ADDR_W-1:0] rs1_r, rs2_r, rd_r;
  logic [DATA_W-1:0] op_a_r, op_b_r;
  logic [ADDR_W-1:0] op_rd_r;
  logic              op_valid_r;
  logic              wb_req_s, guard_s, req_ready_s, accept_s, take_s;

  // A write to index 0 is acknowledged but never reaches the file.
  assign wb_req_s = wb_valid & (wb_rd != ZERO_IDX);

`ifdef RF_OPF_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STALL_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_LIMIT);
  logic [CNT_W-1:0] stall_cnt_r;

  // Guard fires for one cycle once the read has been blocked STALL_LIMIT times.
  always_comb begin
    guard_s = (state_r == ISSUE) && (stall_cnt_r == CNT_MAX);
  end

  // Saturating count of consecutive write-blocked read attempts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ISSUE) begin
      if (rf_wr) begin
        if (stall_cnt_r != CNT_MAX) stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        else                        stall_cnt_r <= stall_cnt_r;
      end else begin
        stall_cnt_r <= {CNT_W{1'b0}};
      end
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end
`else
  assign guard_s = 1'b0;
`endif

  assign wb_ready = rst_n & ~guard_s;
  assign rf_wr    = rst_n & wb_req_s & ~guard_s;
  assign rf_rw    = wb_rd;
  assign rf_din   = wb_data;
  assign rf_r1    = rs1_r;
  assign rf_r2    = rs2_r;

  assign req_ready = rst_n & req_ready_s;
  assign op_valid  = op_valid_r;
  assign op_a      = op_a_r;
  assign op_b      = op_b_r;
  assign op_rd     = op_rd_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next-state and handshake decode; the read only lands on an edge with no write.
  always_comb begin
    state_s     = state_r;
    req_ready_s = 1'b0;
    accept_s    = 1'b0;
    take_s      = 1'b0;
    case (state_r)
      IDLE: begin
        req_ready_s = 1'b1;
        if (req_valid) begin
          accept_s = 1'b1;
          state_s  = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (!rf_wr) state_s = CAPT;
        else        state_s = ISSUE;
      end
      CAPT: begin
        state_s = VALID;
      end
      VALID: begin
        req_ready_s = op_ready;
        if (op_ready) begin
          take_s = 1'b1;
          if (req_valid) begin
            accept_s = 1'b1;
            state_s  = ISSUE;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = VALID;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Request latch; operand capture forces register 0 to read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_r      <= ZERO_IDX;
      rs2_r      <= ZERO_IDX;
      rd_r       <= ZERO_IDX;
      op_a_r     <= ZERO_DATA;
      op_b_r     <= ZERO_DATA;
      op_rd_r    <= ZERO_IDX;
      op_valid_r <= 1'b0;
    end else begin
      if (accept_s) begin
        rs1_r <= req_rs1;
        rs2_r <= req_rs2;
        rd_r  <= req_rd;
      end else begin
        rs1_r <= rs1_r;
        rs2_r <= rs2_r;
        rd_r  <= rd_r;
      end
      if (state_r == CAPT) begin
        op_a_r     <= (rs1_r == ZERO_IDX) ? ZERO_DATA : rf_out1;
        op_b_r     <= (rs2_r == ZERO_IDX) ? ZERO_DATA : rf_out2;
        op_rd_r    <= rd_r;
        op_valid_r <= 1'b1;
      end else if (take_s) begin
        op_valid_r <= 1'b0;
      end else begin
        op_valid_r <= op_valid_r;
      end
    end
  end

endmodule

// File: tb/tb_rf_operand_fetch.sv
// Scoreboard bench for rf_operand_fetch with a behavioural registered-read register file.
module tb_rf_operand_fetch;
  import rf_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, req_valid, req_ready, wb_valid, wb_ready, rf_wr;
  logic              op_valid, op_ready;
  logic [ADDR_W-1:0] req_rs1, req_rs2, req_rd, wb_rd, rf_rw, rf_r1, rf_r2, op_rd;
  logic [DATA_W-1:0] wb_data, rf_din, rf_out1, rf_out2, op_a, op_b;

  rf_operand_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_wr(rf_wr), .rf_rw(rf_rw), .rf_din(rf_din),
    .rf_r1(rf_r1), .rf_r2(rf_r2), .rf_out1(rf_out1), .rf_out2(rf_out2),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_rd(op_rd)
  );

  // Register file: one write or one read per edge, read data registered.
  logic [DATA_W-1:0] mem [0:31];
  logic              mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      rf_out1 <= 32'h0;
      rf_out2 <= 32'h0;
    end else if (rf_wr) begin
      mem[rf_rw] <= rf_din;
    end else begin
      rf_out1 <= mem[rf_r1];
      rf_out2 <= mem[rf_r2];
    end
  end

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] ref_mem [0:31];
  int          total = 0;
  int          bad = 0;
  int          edges;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_req(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    exp_t e;
    req_valid = 1'b1;
    req_rs1 = rs1; req_rs2 = rs2; req_rd = rd;
    e.a  = (rs1 == 5'd0) ? 32'h0 : ref_mem[rs1];
    e.b  = (rs2 == 5'd0) ? 32'h0 : ref_mem[rs2];
    e.rd = rd;
    sbq.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    check({tag, "_sb_depth"}, 32'(sbq.size()), 32'd1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check({tag, "_op_a"}, op_a, e.a);
      check({tag, "_op_b"}, op_b, e.b);
      check({tag, "_op_rd"}, 32'(op_rd), 32'(e.rd));
    end
  endtask

  task automatic wait_op();
    while (!op_valid && edges < 20) begin
      @(posedge clk); edges++; @(negedge clk);
    end
  endtask

  task automatic consume();
    op_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    op_ready = 1'b0;
    #1 check("op_dropped", op_valid, 1'b0);
  endtask

  task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
    wb_valid = 1'b1; wb_rd = rd; wb_data = data;
    #1 check("wb_ready", wb_ready, 1'b1);
    check("wb_rf_wr", rf_wr, rd != 5'd0);
    @(posedge clk);
    if (rd != 5'd0) ref_mem[rd] = data;
    @(negedge clk);
    wb_valid = 1'b0;
  endtask

  task automatic run_req(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input int ncol, input logic [4:0] colrd,
                         input logic [31:0] coldata);
    push_req(rs1, rs2, rd);
    #1 check({tag, "_req_ready"}, req_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    edges = 0;
    for (int c = 0; c < ncol; c++) begin
      wb_valid = 1'b1; wb_rd = colrd; wb_data = coldata;
      #1 check({tag, "_col_rf_wr"}, rf_wr, 1'b1);
      @(posedge clk); edges++;
      ref_mem[colrd] = coldata;
      @(negedge clk);
    end
    wb_valid = 1'b0;
    wait_op();
    check({tag, "_latency"}, 32'(edges), 32'(2 + ncol));
    pop_cmp(tag);
    consume();
  endtask

  initial begin
    rst_n = 1'b0; mem_init = 1'b1;
    req_valid = 1'b0; req_rs1 = 5'd0; req_rs2 = 5'd0; req_rd = 5'd0;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h5555_5555; op_ready = 1'b0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'hA500_0000 | 32'(i);
    #1;
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_wb_ready", wb_ready, 1'b0);
    check("rst_rf_wr", rf_wr, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0; wb_valid = 1'b0; rst_n = 1'b1;
    #1;
    check("post_rst_req_ready", req_ready, 1'b1);
    check("post_rst_op_valid", op_valid, 1'b0);
    check("post_rst_op_a", op_a, 32'h0);
    check("post_rst_rf_r1", 32'(rf_r1), 32'h0);
    @(negedge clk);

    // Basic write-back then read; op_b from register 0.
    wb_write(5'd3, 32'hDEAD_BEEF);
    run_req("basic", 5'd3, 5'd0, 5'd9, 0, 5'd0, 32'h0);

    // Two colliding write-backs during ISSUE, then read back the written register.
    run_req("collide", 5'd5, 5'd6, 5'd10, 2, 5'd7, 32'h1234_5678);
    run_req("readback", 5'd7, 5'd5, 5'd11, 0, 5'd0, 32'h0);

    // Write-back to register 0 is accepted and dropped.
    wb_write(5'd0, 32'hFFFF_FFFF);
    run_req("zero", 5'd0, 5'd3, 5'd12, 0, 5'd0, 32'h0);

    // Hold operands under back-pressure and a write to the held source.
    push_req(5'd3, 5'd5, 5'd13);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; edges = 0;
    wait_op();
    check("hold_latency", 32'(edges), 32'd2);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
      check("hold_valid", op_valid, 1'b1);
      check("hold_op_a", op_a, sbq[0].a);
    end
    wb_write(5'd3, 32'h0BAD_F00D);
    #1 check("hold_after_wb", op_a, sbq[0].a);
    pop_cmp("hold");
    op_ready = 1'b1;
    push_req(5'd4, 5'd3, 5'd14);
    #1 check("b2b_req_ready", req_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; op_ready = 1'b0; edges = 0;
    #1 check("b2b_op_cleared", op_valid, 1'b0);
    check("b2b_in_issue", req_ready, 1'b0);
    wait_op();
    check("b2b_latency", 32'(edges), 32'd2);
    pop_cmp("b2b");
    consume();

    // Asynchronous reset while the stage sits in CAPT.
    req_valid = 1'b1; req_rs1 = 5'd1; req_rs2 = 5'd2; req_rd = 5'd15;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_op_valid", op_valid, 1'b0);
    check("arst_req_ready", req_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("arst_idle", req_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    check("arst_no_capture", op_valid, 1'b0);

    // Varied write-then-read patterns.
    for (int k = 0; k < 6; k++) begin
      logic [4:0]  r;
      logic [31:0] d;
      r = 5'($urandom_range(1, 31));
      d = $urandom;
      wb_write(r, d);
      run_req("mix", r, 5'($urandom_range(0, 31)), 5'(k), 0, 5'd0, 32'h0);
    end

`ifdef RF_OPF_STARVE_GUARD_EN
    // Continuous write-back: guard steals one cycle after STALL_LIMIT blocked reads.
    push_req(5'd9, 5'd2, 5'd16);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; edges = 0;
    wb_valid = 1'b1; wb_rd = 5'd8; wb_data = 32'hCAFE_0008;
    for (int c = 0; c < 4; c++) begin
      #1 check("guard_blocked_wb_ready", wb_ready, 1'b1);
      check("guard_blocked_rf_wr", rf_wr, 1'b1);
      @(posedge clk); edges++;
      ref_mem[8] = 32'hCAFE_0008;
      @(negedge clk);
    end
    #1 check("guard_wb_ready", wb_ready, 1'b0);
    check("guard_rf_wr", rf_wr, 1'b0);
    @(posedge clk); edges++; @(negedge clk);
    wb_valid = 1'b0;
    wait_op();
    check("guard_latency", 32'(edges), 32'd6);
    pop_cmp("guard");
    consume();
`else
    // Without the guard, every colliding cycle delays the read.
    run_req("starve", 5'd9, 5'd2, 5'd16, 6, 5'd8, 32'hCAFE_0008);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
